// File: rtl/mult_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_pkg
//
// Purpose : Shared definitions for the iterative multiply/divide unit. The
//           CPU control unit imports the op encodings from here so that the
//           value it drives on `op` always agrees with the datapath.
//
// Contents: OP_MULT / OP_DIV   operation select encodings
//           ITERATIONS         number of shift steps per operation
//           state_t, ST_*      control FSM state encodings
// ---------------------------------------------------------------------------
package mult_div_pkg;

    // Operation select carried on the `op` input.
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    // One shift step per operand bit at the default 32-bit width.
    localparam int ITERATIONS = 32;

    // Control FSM states, kept as plain constants so older tools and the
    // control-unit decoder can compare against them directly.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_MULT   = 2'd1;
    localparam state_t ST_DIV    = 2'd2;
    localparam state_t ST_FINISH = 2'd3;

endpackage

// File: rtl/mult_div_unit_if.sv
// ---------------------------------------------------------------------------
// mult_div_unit_if
//
// Purpose : Bundles the launch handshake, operands and results exchanged
//           between the CPU control/datapath and the multiply/divide unit.
//
// Signals : start     launch request (sampled only while the unit is idle)
//           op        0 = MULT, 1 = DIV (sampled with start)
//           a, b      two's-complement operands (sampled with start)
//           hi, lo    result registers (product halves or remainder/quotient)
//           busy      operation in flight
//           done      one-cycle pulse, hi/lo valid in the same cycle
//           div_zero  one-cycle pulse for a DIV launched with b == 0
//
// Modports: master  CPU side, drives the request and reads results
//           slave   the unit itself
// ---------------------------------------------------------------------------
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);

    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start,
        output op,
        output a,
        output b,
        input  hi,
        input  lo,
        input  busy,
        input  done,
        input  div_zero
    );

    modport slave (
        input  start,
        input  op,
        input  a,
        input  b,
        output hi,
        output lo,
        output busy,
        output done,
        output div_zero
    );

endinterface

// File: rtl/mult_div_unit_signfix.sv
// ---------------------------------------------------------------------------
// mult_div_signfix
//
// Purpose : Combinational conditional two's-complement negate. Used both to
//           take operand magnitudes (negate = sign bit) and to restore the
//           sign of a result after the unsigned iteration (negate = result
//           sign flag).
//
// Ports   : value   [WIDTH-1:0]  input word
//           negate               1 = output the two's-complement negation
//           result  [WIDTH-1:0]  value or -value
// ---------------------------------------------------------------------------
module mult_div_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    // Negating the most negative number wraps back to itself, which is the
    // correct unsigned magnitude (2^(WIDTH-1)) for the datapath.
    assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Purpose : Iterative signed multiply/divide unit feeding the HI/LO inputs of
//           the register-file write-data mux. MULT yields the exact signed
//           64-bit product; DIV yields a quotient truncated toward zero and a
//           remainder carrying the dividend's sign. Both take a fixed 33
//           cycles from the start edge to the done pulse. A DIV with a zero
//           divisor is refused in IDLE and reported with a div_zero pulse.
//
// Ports   : clk     rising-edge clock
//           reset   synchronous, active-low
//           bus     mult_div_unit_if.slave (start/op/a/b in,
//                   hi/lo/busy/done/div_zero out)
// ---------------------------------------------------------------------------
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);

    localparam int                CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic                 op_reg;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 neg_lo;
    logic                 neg_hi;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     hi_reg;
    logic [WIDTH-1:0]     lo_reg;
    logic                 done_reg;
    logic                 div_zero_reg;

    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [2*WIDTH-1:0]   prod_fixed;
    logic [WIDTH-1:0]     quot_fixed;
    logic [WIDTH-1:0]     rem_fixed;

    logic [WIDTH:0]       mult_sum;
    logic [2*WIDTH-1:0]   mult_next;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   div_next;

    // Operand magnitudes are taken straight from the bus so they can be
    // latched on the same edge that accepts start.
    mult_div_signfix #(.WIDTH(WIDTH)) u_abs_a (
        .value  (bus.a),
        .negate (bus.a[WIDTH-1]),
        .result (abs_a)
    );

    mult_div_signfix #(.WIDTH(WIDTH)) u_abs_b (
        .value  (bus.b),
        .negate (bus.b[WIDTH-1]),
        .result (abs_b)
    );

    // The product is negated as one 64-bit word so the borrow propagates
    // from LO into HI.
    mult_div_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .value  (acc),
        .negate (neg_lo),
        .result (prod_fixed)
    );

    // Quotient and remainder carry independent signs, so they are fixed up
    // separately.
    mult_div_signfix #(.WIDTH(WIDTH)) u_fix_quot (
        .value  (acc[WIDTH-1:0]),
        .negate (neg_lo),
        .result (quot_fixed)
    );

    mult_div_signfix #(.WIDTH(WIDTH)) u_fix_rem (
        .value  (acc[2*WIDTH-1:WIDTH]),
        .negate (neg_hi),
        .result (rem_fixed)
    );

    // Shift-add step. The multiplier sits in the low half of acc and is
    // consumed from bit 0 while the partial product grows in the high half;
    // the extra carry bit of the addition becomes the new top bit after the
    // right shift.
    assign mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
    assign mult_next = acc[0] ? {mult_sum, acc[WIDTH-1:1]}
                              : {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};

    // Restoring division step. acc holds {remainder, dividend/quotient}.
    // The remainder shifted left by one needs WIDTH+1 bits; the top bit of
    // the trial difference is set exactly when the subtraction would go
    // negative, in which case the shifted remainder is kept unchanged.
    assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
    assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // Control FSM, iteration counter and all result registers. IDLE accepts
    // a launch (or refuses a divide by zero), MULT/DIV run one step per
    // cycle for WIDTH cycles, and FINISH applies the sign fix-up, loads
    // HI/LO and pulses done. hi/lo are touched only in FINISH, so an abort
    // by reset or a divide-by-zero never leaves a partial result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            count        <= '0;
            op_reg       <= OP_MULT;
            mag_a        <= '0;
            mag_b        <= '0;
            neg_lo       <= 1'b0;
            neg_hi       <= 1'b0;
            acc          <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.op == OP_DIV && bus.b == '0) begin
                            div_zero_reg <= 1'b1;
                        end else begin
                            op_reg <= bus.op;
                            mag_a  <= abs_a;
                            mag_b  <= abs_b;
                            neg_lo <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                            neg_hi <= bus.a[WIDTH-1];
                            count  <= '0;
                            if (bus.op == OP_MULT) begin
                                acc   <= {{WIDTH{1'b0}}, abs_b};
                                state <= ST_MULT;
                            end else begin
                                acc   <= {{WIDTH{1'b0}}, abs_a};
                                state <= ST_DIV;
                            end
                        end
                    end
                end

                ST_MULT: begin
                    acc   <= mult_next;
                    count <= count + CNT_W'(1);
                    if (count == LAST_ITER) begin
                        state <= ST_FINISH;
                    end
                end

                ST_DIV: begin
                    acc   <= div_next;
                    count <= count + CNT_W'(1);
                    if (count == LAST_ITER) begin
                        state <= ST_FINISH;
                    end
                end

                ST_FINISH: begin
                    if (op_reg == OP_MULT) begin
                        hi_reg <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fixed[WIDTH-1:0];
                    end else begin
                        hi_reg <= rem_fixed;
                        lo_reg <= quot_fixed;
                    end
                    done_reg <= 1'b1;
                    state    <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // busy follows the state directly, so it drops in the same cycle that
    // done rises and a new start can be accepted right away.
    assign bus.busy     = (state != ST_IDLE);
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
    assign bus.done     = done_reg;
    assign bus.div_zero = div_zero_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//
// Purpose : Self-checking bench for mult_div_unit. Directed cases cover the
//           sign, overflow, divide-by-zero, collision and reset scenarios;
//           a randomized loop checks results against a reference model
//           built on native 64-bit signed arithmetic.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;
    import mult_div_pkg::*;

    localparam int WIDTH    = 32;
    localparam int LATENCY  = 33;
    localparam int MAX_WAIT = 60;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Signed reference: MULT is the full 64-bit product, DIV uses native
    // truncating division and remainder on sign-extended operands.
    function automatic void model(input logic op, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] exp_hi,
                                  output logic [31:0] exp_lo);
        longint sa;
        longint sb;
        longint res_p;
        longint res_q;
        longint res_r;
        sa = $signed(a);
        sb = $signed(b);
        if (op == OP_MULT) begin
            res_p  = sa * sb;
            exp_hi = res_p[63:32];
            exp_lo = res_p[31:0];
        end else begin
            res_q  = sa / sb;
            res_r  = sa % sb;
            exp_hi = res_r[31:0];
            exp_lo = res_q[31:0];
        end
    endfunction

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a launch for one edge, then scramble the operand inputs so the
    // unit must rely on its own copies.
    task automatic apply_stimulus(input logic op, input logic [31:0] a,
                                  input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        step();
        bus.start = 1'b0;
        bus.op    = 1'($urandom_range(1, 0));
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Wait for done, bounded. Optionally fires a colliding start after edge
    // k+inject_at. Returns the number of edges from the start edge to done,
    // whether busy stayed high until then, and whether div_zero stayed low.
    task automatic wait_done(input int inject_at, output int latency,
                             output bit busy_held, output bit quiet);
        latency   = 0;
        busy_held = (bus.busy === 1'b1);
        quiet     = 1'b1;
        for (int j = 1; j <= MAX_WAIT; j++) begin
            step();
            bus.start = 1'b0;
            if (bus.div_zero !== 1'b0) quiet = 1'b0;
            if (bus.done === 1'b1) begin
                latency = j;
                break;
            end
            if (bus.busy !== 1'b1) busy_held = 1'b0;
            if (j == inject_at) begin
                bus.start = 1'b1;
                bus.op    = 1'($urandom_range(1, 0));
                bus.a     = $urandom;
                bus.b     = (bus.op == OP_DIV) ? 32'h0 : $urandom;
            end
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] exp_hi,
                                input logic [31:0] exp_lo, input int latency,
                                input bit busy_held, input bit quiet);
        check_value({tag, " latency"}, 32'(latency), 32'(LATENCY));
        check_value({tag, " busy_held"}, 32'(busy_held), 32'd1);
        check_value({tag, " no_div_zero"}, 32'(quiet), 32'd1);
        check_value({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
        check_value({tag, " hi"}, bus.hi, exp_hi);
        check_value({tag, " lo"}, bus.lo, exp_lo);
    endtask

    task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int inject_at);
        int lat;
        bit held;
        bit quiet;
        apply_stimulus(op, a, b);
        wait_done(inject_at, lat, held, quiet);
        check_output(tag, exp_hi, exp_lo, lat, held, quiet);
    endtask

    initial begin
        logic [31:0] corners [6];
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rop;
        logic [31:0] eh;
        logic [31:0] el;
        bit          seen_done;

        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0001};

        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state.
        reset = 1'b0;
        repeat (3) step();
        check_value("reset hi", bus.hi, 32'h0);
        check_value("reset lo", bus.lo, 32'h0);
        check_value("reset busy", 32'(bus.busy), 32'd0);
        check_value("reset done", 32'(bus.done), 32'd0);
        check_value("reset div_zero", 32'(bus.div_zero), 32'd0);
        reset = 1'b1;
        step();

        // 7 * -3, then confirm done is a single-cycle pulse.
        run_op("mult 7*-3", OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1);
        step();
        check_value("mult 7*-3 done_pulse", 32'(bus.done), 32'd0);

        run_op("mult min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, -1);
        step();

        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
        step();

        // Overflow case, then a new DIV launched in the done cycle.
        run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, -1);
        run_op("div 100/7 chained", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, -1);
        step();

        // Seed hi with a known remainder, then divide by zero.
        run_op("div rem seed", OP_DIV, 32'h1234_5678, 32'h7FFF_FFFF, 32'h1234_5678, 32'h0, -1);
        step();
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = $urandom;
        bus.b     = 32'h0;
        step();
        bus.start = 1'b0;
        check_value("divzero pulse", 32'(bus.div_zero), 32'd1);
        check_value("divzero busy", 32'(bus.busy), 32'd0);
        check_value("divzero done", 32'(bus.done), 32'd0);
        check_value("divzero hi_hold", bus.hi, 32'h1234_5678);
        check_value("divzero lo_hold", bus.lo, 32'h0);
        step();
        check_value("divzero pulse_end", 32'(bus.div_zero), 32'd0);
        check_value("divzero still_idle", 32'(bus.busy), 32'd0);

        // Colliding start at iteration 5 must be ignored.
        model(OP_MULT, 32'h0001_2345, 32'hFFFE_0001, eh, el);
        run_op("mult collision", OP_MULT, 32'h0001_2345, 32'hFFFE_0001, eh, el, 5);
        step();

        // Reset at iteration 10: abort with cleared results and no done.
        apply_stimulus(OP_MULT, 32'h0BAD_CAFE, 32'h7654_3210);
        for (int j = 1; j <= 10; j++) step();
        reset = 1'b0;
        step();
        check_value("abort busy", 32'(bus.busy), 32'd0);
        check_value("abort hi", bus.hi, 32'h0);
        check_value("abort lo", bus.lo, 32'h0);
        check_value("abort done", 32'(bus.done), 32'd0);
        reset     = 1'b1;
        seen_done = 1'b0;
        for (int j = 0; j < 40; j++) begin
            step();
            if (bus.done !== 1'b0) seen_done = 1'b1;
        end
        check_value("abort no_done", 32'(seen_done), 32'd0);

        // Randomized operations with sign corners, some chained back to back.
        for (int i = 0; i < 24; i++) begin
            rop = 1'($urandom_range(1, 0));
            ra  = ($urandom_range(3, 0) == 0) ? corners[$urandom_range(5, 0)] : $urandom;
            rb  = ($urandom_range(3, 0) == 0) ? corners[$urandom_range(5, 0)] : $urandom;
            if (rop == OP_DIV && rb == 32'h0) rb = 32'h1;
            model(rop, ra, rb, eh, el);
            run_op($sformatf("rand%0d %s", i, (rop == OP_MULT) ? "mult" : "div"),
                   rop, ra, rb, eh, el, -1);
            if ($urandom_range(1, 0) == 0) begin
                step();
                check_value($sformatf("rand%0d done_pulse", i), 32'(bus.done), 32'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
